// File: rtl/vga_fb_writer_pkg.sv
// Shared types for the VGA framebuffer write engine: pixel/byte/word types,
// the buffered store record, the engine state, and lane-selection helpers.
package vga_fb_writer_pkg;

   typedef logic [18:0] Vga_addr_t;
   typedef logic [7:0]  Byte_t;
   typedef logic [31:0] Word_t;

   localparam int VGA_PIXELS = 480000;

   typedef struct packed {
      Vga_addr_t  addr;
      Word_t      data;
      logic [3:0] be;
   } Fb_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FILL  = 2'd2
   } Fb_writer_state_t;

   // Lanes that will actually be written: enabled and inside the framebuffer.
   // The sum is formed in 20 bits so addresses near the top cannot wrap.
   function automatic logic [3:0] lane_mask(input Fb_req_t req, input logic [19:0] limit);
      logic [3:0] m;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         m[k] = req.be[k] && (({1'b0, req.addr} + 20'(k)) < limit);
      end
      return m;
   endfunction

   function automatic logic [1:0] first_lane(input logic [3:0] m);
      logic [1:0] l;
      l = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (m[k]) l = 2'(k);
      end
      return l;
   endfunction

endpackage

// File: rtl/vga_fb_writer_fifo.sv
// Synchronous store-request FIFO; pushes when full and pops when empty are dropped.
module fb_req_fifo
   import vga_fb_writer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  Fb_req_t din,
   output Fb_req_t dout,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   Fb_req_t        mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define
   // which entries are meaningful, so flushing only needs them cleared.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vga_fb_writer.sv
// Framebuffer write engine: buffers 32-bit byte-enabled stores and serialises
// them into one-byte writes, or paints the whole screen with one colour.
module vga_fb_writer
   import vga_fb_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FB_PIXELS  = VGA_PIXELS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [18:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [3:0] req_be,
   input  logic       fill_start,
   input  logic [7:0] fill_color,
   output logic       busy,
   output logic       write_en,
   output logic [18:0] bus_addr,
   output logic [7:0] bus_data
);

   localparam logic [19:0] FB_LIMIT  = 20'(FB_PIXELS);
   localparam Vga_addr_t   LAST_ADDR = Vga_addr_t'(FB_PIXELS - 1);

   Fb_writer_state_t state;
   Fb_writer_state_t state_next;

   Fb_req_t    head;
   Fb_req_t    req_in;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   logic       start_fill;

   Vga_addr_t  cur_addr;
   Word_t      cur_data;
   logic [3:0] pend;
   logic [3:0] pend_rest;
   logic [1:0] lane;
   logic       lane_last;

   Vga_addr_t  fill_addr;
   Byte_t      fill_byte;

   assign req_in    = '{addr: req_addr, data: req_data, be: req_be};
   assign req_ready = !fifo_full && (state != ST_FILL);
   assign push      = req_valid && req_ready;
   // write_en is included so busy covers the cycle in which the final write is visible.
   assign busy      = (state != ST_IDLE) || !fifo_empty || write_en;

   assign lane      = first_lane(pend);
   assign pend_rest = pend & ~(4'b0001 << lane);
   assign lane_last = (pend_rest == 4'b0000);

   fb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (req_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty)     state_next = ST_DRAIN;
            else if (start_fill) state_next = ST_FILL;
         end
         ST_DRAIN: if (lane_last && fifo_empty) state_next = ST_IDLE;
         ST_FILL:  if (fill_addr == LAST_ADDR)  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // NOTE: every output of this block gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      pop        = 1'b0;
      start_fill = 1'b0;
      case (state)
         ST_IDLE: begin
            pop        = !fifo_empty;
            start_fill = fifo_empty && !write_en && fill_start;
         end
         ST_DRAIN: pop = lane_last && !fifo_empty;
         default: ;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_en  <= 1'b0;
         bus_addr  <= '0;
         bus_data  <= '0;
         cur_addr  <= '0;
         cur_data  <= '0;
         pend      <= '0;
         fill_addr <= '0;
         fill_byte <= '0;
      end else begin
         write_en <= 1'b0;

         if (pop) begin
            cur_addr <= head.addr;
            cur_data <= head.data;
            pend     <= lane_mask(head, FB_LIMIT);
         end else if (state == ST_DRAIN) begin
            pend <= pend_rest;
         end

         if (state == ST_DRAIN && pend != 4'b0000) begin
            write_en <= 1'b1;
            bus_addr <= cur_addr + Vga_addr_t'(lane);
            bus_data <= cur_data[{lane, 3'b000} +: 8];
         end

         if (start_fill) begin
            fill_byte <= fill_color;
            fill_addr <= '0;
         end else if (state == ST_FILL) begin
            write_en  <= 1'b1;
            bus_addr  <= fill_addr;
            bus_data  <= fill_byte;
            fill_addr <= fill_addr + Vga_addr_t'(1);
         end
      end
   end

endmodule
